// File: rtl/joe_motion.sv
// Per-frame position and hit-state controller for the Joe sprite.
// Advances once per rising vsync edge: walking, then rise/fall/respawn-wait after a hit.
//
// state | meaning
// WALK  | keyboard-controlled horizontal walking
// RISE  | sprite rises after a collision for RISE_FRAMES frames
// FALL  | sprite falls back to ground level
// WAIT  | sprite held at ground for WAIT_FRAMES frames, then respawns at X_START
module joe_motion #(
  parameter int X_START     = 320,
  parameter int Y_START     = 400,
  parameter int X_MIN       = 42,
  parameter int X_MAX       = 597,
  parameter int Y_MIN       = 46,
  parameter int STEP        = 2,
  parameter int FLY_VY      = 4,
  parameter int RISE_FRAMES = 20,
  parameter int WAIT_FRAMES = 60
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       vsync,
  input  logic [7:0] keycode,
  input  logic       collide,
  output logic [9:0] centerx,
  output logic [9:0] centery,
  output logic [1:0] hit_joe
);

  localparam int T_MAX = (RISE_FRAMES > WAIT_FRAMES) ? RISE_FRAMES : WAIT_FRAMES;
  localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [10:0] X_LO_11  = 11'(X_MIN + STEP);
  localparam logic [10:0] X_MAX_11 = 11'(X_MAX);
  localparam logic [10:0] Y_LO_11  = 11'(Y_MIN + FLY_VY);
  localparam logic [10:0] Y_GND_11 = 11'(Y_START);
  localparam logic [10:0] STEP_11  = 11'(STEP);
  localparam logic [10:0] VY_11    = 11'(FLY_VY);

  typedef enum logic [1:0] {
    WALK = 2'b00,
    RISE = 2'b01,
    FALL = 2'b10,
    WAIT = 2'b11
  } state_t;

  state_t          state_q, state_d;
  logic [9:0]      x_q, x_d, y_q, y_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            vs_q, collide_pend, frame;
  logic [10:0]     x_ext, y_ext, x_inc, x_dec, y_up, y_down;

  assign frame = vsync & ~vs_q;

  // All position arithmetic is done one bit wider so it cannot wrap.
  assign x_ext  = {1'b0, x_q};
  assign y_ext  = {1'b0, y_q};
  assign x_inc  = x_ext + STEP_11;
  assign x_dec  = x_ext - STEP_11;
  assign y_up   = y_ext - VY_11;
  assign y_down = y_ext + VY_11;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    timer_d = timer_q;
    case (state_q)
      WALK: begin
        if (collide_pend || collide) begin
          state_d = RISE;
          timer_d = TW'(RISE_FRAMES - 1);
        end else if (keycode == 8'h04) begin
          x_d = (x_ext < X_LO_11) ? 10'(X_MIN) : x_dec[9:0];
        end else if (keycode == 8'h07) begin
          x_d = (x_inc > X_MAX_11) ? 10'(X_MAX) : x_inc[9:0];
        end
      end
      RISE: begin
        y_d = (y_ext < Y_LO_11) ? 10'(Y_MIN) : y_up[9:0];
        if (timer_q == '0) state_d = FALL;
        else               timer_d = timer_q - 1'b1;
      end
      FALL: begin
        if (y_down >= Y_GND_11) begin
          y_d     = 10'(Y_START);
          state_d = WAIT;
          timer_d = TW'(WAIT_FRAMES - 1);
        end else begin
          y_d = y_down[9:0];
        end
      end
      WAIT: begin
        if (timer_q == '0) begin
          state_d = WALK;
          x_d     = 10'(X_START);
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = WALK;
    endcase
  end

  // vs_q resets high so a vsync already high at release is not seen as an edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vs_q         <= 1'b1;
      collide_pend <= 1'b0;
      state_q      <= WALK;
      x_q          <= 10'(X_START);
      y_q          <= 10'(Y_START);
      timer_q      <= '0;
    end else begin
      vs_q <= vsync;
      if (frame)        collide_pend <= 1'b0;
      else if (collide) collide_pend <= 1'b1;
      if (frame) begin
        state_q <= state_d;
        x_q     <= x_d;
        y_q     <= y_d;
        timer_q <= timer_d;
      end
    end
  end

  assign centerx = x_q;
  assign centery = y_q;
  assign hit_joe = state_q;

endmodule

// File: tb/tb_joe_motion.sv
// Scoreboard bench for joe_motion: stimulus queues expected per-frame outputs,
// a monitor spotting each vsync rising edge pops and compares them.
module tb_joe_motion;

  logic       Clk = 1'b0;
  logic       Reset, vsync, collide;
  logic [7:0] keycode;
  logic [9:0] centerx, centery;
  logic [1:0] hit_joe;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] h;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  joe_motion dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .vsync   (vsync),
    .keycode (keycode),
    .collide (collide),
    .centerx (centerx),
    .centery (centery),
    .hit_joe (hit_joe)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [9:0] gx, input logic [9:0] gy,
                       input logic [1:0] gh, input logic [9:0] ex, input logic [9:0] ey,
                       input logic [1:0] eh);
    n_total++;
    if (gx !== ex || gy !== ey || gh !== eh)
      $display("FAIL %s: got x=%0d y=%0d hit=%b, expected x=%0d y=%0d hit=%b",
               name, gx, gy, gh, ex, ey, eh);
    else
      n_pass++;
  endtask

  // Monitor: tracks vsync itself and compares one queued entry per frame edge.
  initial begin
    logic tb_vs, fr;
    exp_t e;
    tb_vs = 1'b1;
    forever begin
      @(posedge Clk);
      fr    = vsync && !tb_vs && !Reset;
      tb_vs = Reset ? 1'b1 : vsync;
      if (fr) begin
        #1;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_frame: got frame update, expected none queued");
        end else begin
          e = exp_q.pop_front();
          check("frame", centerx, centery, hit_joe, e.x, e.y, e.h);
        end
      end
    end
  end

  task automatic frame(input logic col, input int ex, input int ey, input int eh);
    exp_t e;
    e.x = 10'(ex);
    e.y = 10'(ey);
    e.h = 2'(eh);
    exp_q.push_back(e);
    collide = col;
    @(negedge Clk) vsync = 1'b1;
    @(negedge Clk) vsync = 1'b0;
    collide = 1'b0;
    @(negedge Clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1);
  end

  initial begin
    int ex, ey;
    Reset = 1'b1; vsync = 1'b1; keycode = 8'h07; collide = 1'b0;
    repeat (3) @(negedge Clk);
    check("reset_values", centerx, centery, hit_joe, 10'd320, 10'd400, 2'd0);
    Reset = 1'b0;
    repeat (4) @(negedge Clk);
    check("no_edge_vsync_high", centerx, centery, hit_joe, 10'd320, 10'd400, 2'd0);
    vsync = 1'b0;
    @(negedge Clk);

    // walk right, saturating at 597
    ex = 320;
    for (int i = 0; i < 150; i++) begin
      ex = (ex + 2 > 597) ? 597 : ex + 2;
      frame(1'b0, ex, 400, 0);
    end
    check("x_hold_max", centerx, centery, hit_joe, 10'd597, 10'd400, 2'd0);

    @(negedge Clk) Reset = 1'b1;
    @(negedge Clk) Reset = 1'b0;
    check("reset_again", centerx, centery, hit_joe, 10'd320, 10'd400, 2'd0);

    // walk left, saturating at 42
    keycode = 8'h04;
    ex = 320;
    for (int i = 0; i < 200; i++) begin
      ex = (ex < 44) ? 42 : ex - 2;
      frame(1'b0, ex, 400, 0);
    end

    // one-cycle collide pulse between frames, then full hit sequence with key/collide noise
    keycode = 8'h00;
    @(negedge Clk) collide = 1'b1;
    @(negedge Clk) collide = 1'b0;
    @(negedge Clk);
    frame(1'b0, 42, 400, 1);
    keycode = 8'h07;
    for (int i = 1; i <= 20; i++) frame(i % 5 == 0, 42, 400 - 4 * i, (i == 20) ? 2 : 1);
    for (int j = 1; j <= 20; j++) frame(j % 6 == 0, 42, (j == 20) ? 400 : 320 + 4 * j, (j == 20) ? 3 : 2);
    for (int k = 1; k <= 60; k++) frame(k < 50 && k % 7 == 0, (k == 60) ? 320 : 42, 400, (k == 60) ? 0 : 3);
    keycode = 8'h00;
    frame(1'b0, 320, 400, 0);
    frame(1'b0, 320, 400, 0);

    // collide in the frame cycle itself, then reset during FALL with a pending collide
    frame(1'b1, 320, 400, 1);
    keycode = 8'h07;
    for (int i = 1; i <= 20; i++) frame(1'b0, 320, 400 - 4 * i, (i == 20) ? 2 : 1);
    ey = 320;
    for (int j = 1; j <= 3; j++) begin
      ey = ey + 4;
      frame(1'b0, 320, ey, 2);
    end
    @(negedge Clk) collide = 1'b1;
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1 check("async_reset_fall", centerx, centery, hit_joe, 10'd320, 10'd400, 2'd0);
    collide = 1'b0;
    keycode = 8'h00;
    @(negedge Clk) Reset = 1'b0;
    @(negedge Clk);
    frame(1'b0, 320, 400, 0);

    repeat (5) @(negedge Clk);
    n_total++;
    if (exp_q.size() != 0)
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
    else
      n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
